// File: rtl/text_cursor_ctrl_if.sv
// rtl/text_cursor_ctrl_if.sv - byte intake and text memory write bus for the cursor controller
interface text_cursor_ctrl_if;
    logic [7:0]  uart_data;
    logic        data_ready;
    logic [7:0]  write_data;
    logic [12:0] write_address;
    logic        write_enable;
    logic        busy;
    logic        overflow;

    modport master (
        input  uart_data, data_ready,
        output write_data, write_address, write_enable, busy, overflow
    );

    modport slave (
        output uart_data, data_ready,
        input  write_data, write_address, write_enable, busy, overflow
    );
endinterface

// File: rtl/text_cursor_ctrl.sv
// rtl/text_cursor_ctrl.sv - terminal-style cursor engine turning received bytes into text memory writes
module text_cursor_ctrl #(
    parameter int          COLS      = 100,
    parameter int          ROWS      = 37,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic                  clock,
    input  logic                  reset,
    text_cursor_ctrl_if.master    bus
);
    typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_ALL} state_t;

    localparam logic [12:0] COL_LAST   = 13'(COLS - 1);
    localparam logic [12:0] ROW_LAST   = 13'(ROWS - 1);
    localparam logic [12:0] COLS_W     = 13'(COLS);
    localparam logic [13:0] LINE_COUNT = 14'(COLS);
    localparam logic [13:0] ALL_COUNT  = 14'(COLS * ROWS);

    state_t      state, state_n;
    logic [12:0] row, row_n, col, col_n, base, base_n;
    logic [13:0] cnt, cnt_n;
    logic        adv, adv_n;
    logic        buf_full, buf_full_n;
    logic [7:0]  buf_data, buf_data_n;
    logic        we_n, ovf_n;
    logic [7:0]  wd_n;
    logic [12:0] wa_n;
    logic        accept;
    logic [7:0]  dbyte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= CLR_ALL;
            row               <= '0;
            col               <= '0;
            base              <= '0;
            cnt               <= '0;
            adv               <= 1'b0;
            buf_full          <= 1'b0;
            buf_data          <= '0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_data    <= FILL_CHAR;
            bus.overflow      <= 1'b0;
        end else begin
            state             <= state_n;
            row               <= row_n;
            col               <= col_n;
            base              <= base_n;
            cnt               <= cnt_n;
            adv               <= adv_n;
            buf_full          <= buf_full_n;
            buf_data          <= buf_data_n;
            bus.write_enable  <= we_n;
            bus.write_address <= wa_n;
            bus.write_data    <= wd_n;
            bus.overflow      <= ovf_n;
        end
    end

    assign bus.busy = (state != IDLE) || buf_full;

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        base_n     = base;
        cnt_n      = cnt;
        adv_n      = adv;
        buf_full_n = buf_full;
        buf_data_n = buf_data;
        we_n       = 1'b0;
        wd_n       = bus.write_data;
        wa_n       = bus.write_address;
        ovf_n      = 1'b0;
        accept     = (state == IDLE) && !buf_full && bus.data_ready;
        dbyte      = buf_full ? buf_data : bus.uart_data;

        // Anything not decoded directly goes to the single pending slot or is dropped.
        if (bus.data_ready && !accept) begin
            if (!buf_full) begin
                buf_full_n = 1'b1;
                buf_data_n = bus.uart_data;
            end else begin
                ovf_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (buf_full || bus.data_ready) begin
                    buf_full_n = 1'b0;
                    if (dbyte >= 8'h20 && dbyte <= 8'h7E) begin
                        state_n = PUT;
                        we_n    = 1'b1;
                        wd_n    = dbyte;
                        wa_n    = base + col;
                        adv_n   = 1'b1;
                    end else begin
                        case (dbyte)
                            8'h0D: col_n = '0;
                            8'h0A: begin
                                row_n   = (row == ROW_LAST) ? '0 : row + 13'd1;
                                base_n  = (row == ROW_LAST) ? '0 : base + COLS_W;
                                cnt_n   = '0;
                                state_n = CLR_LINE;
                            end
                            8'h08: begin
                                if (col != '0) begin
                                    col_n   = col - 13'd1;
                                    state_n = PUT;
                                    we_n    = 1'b1;
                                    wd_n    = FILL_CHAR;
                                    wa_n    = base + col - 13'd1;
                                    adv_n   = 1'b0;
                                end
                            end
                            8'h0C: begin
                                cnt_n   = '0;
                                state_n = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                state_n = IDLE;
                if (adv) begin
                    if (col == COL_LAST) begin
                        col_n   = '0;
                        row_n   = (row == ROW_LAST) ? '0 : row + 13'd1;
                        base_n  = (row == ROW_LAST) ? '0 : base + COLS_W;
                        cnt_n   = '0;
                        state_n = CLR_LINE;
                    end else begin
                        col_n = col + 13'd1;
                    end
                end
            end
            // The clear states linger one cycle past the final write so a byte
            // arriving alongside it is buffered rather than decoded.
            CLR_LINE: begin
                if (cnt == LINE_COUNT) begin
                    state_n = IDLE;
                end else begin
                    we_n  = 1'b1;
                    wd_n  = FILL_CHAR;
                    wa_n  = base + cnt[12:0];
                    cnt_n = cnt + 14'd1;
                end
            end
            CLR_ALL: begin
                if (cnt == ALL_COUNT) begin
                    state_n = IDLE;
                    row_n   = '0;
                    col_n   = '0;
                    base_n  = '0;
                end else begin
                    we_n  = 1'b1;
                    wd_n  = FILL_CHAR;
                    wa_n  = cnt[12:0];
                    cnt_n = cnt + 14'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/text_cursor_ctrl.md
TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

Interface
REQ-001 Parameter COLS, default 100: characters per text row.
REQ-002 Parameter ROWS, default 37: text rows on screen; COLS*ROWS SHALL be at most 8192.
REQ-003 Parameter FILL_CHAR, default 8'h20: code written by every clear operation.
REQ-004 clock  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 uart_data  input  8  received byte, valid only while data_ready is high.
REQ-007 data_ready  input  1  one-cycle pulse marking a new received byte.
REQ-008 write_data  output  8  character code to text memory.
REQ-009 write_address  output  13  text memory address.
REQ-010 write_enable  output  1  text memory write strobe; one write per cycle high.
REQ-011 busy  output  1  high while state is not IDLE or the pending buffer is full.
REQ-012 overflow  output  1  one-cycle pulse when a byte is dropped.

Function
REQ-013 States SHALL be IDLE, PUT, CLR_LINE and CLR_ALL.
REQ-014 Cursor SHALL be held as row (0..ROWS-1) and col (0..COLS-1); address SHALL be row*COLS+col, zero-extended to 13 bits; no multiplier (running row base += COLS).
REQ-015 Byte acceptance: data_ready in IDLE with buffer empty -> byte decoded; otherwise -> stored in the 1-entry pending buffer if empty, else dropped with overflow pulsed the next cycle.
REQ-016 On return to IDLE with buffer full, the pending byte SHALL be decoded next cycle and the buffer emptied.
REQ-017 Printable 0x20..0x7E: PUT, write at cursor; write_enable high exactly 1 cycle, the cycle after acceptance; then col+1.
REQ-018 col wrap: col==COLS-1 after a put -> col=0, row+1 (ROWS-1 wraps to 0), then CLR_LINE on the new row.
REQ-019 0x0D (CR): col=0, no write, stays IDLE.
REQ-020 0x0A (LF): row+1 with wrap, col unchanged, then CLR_LINE on the new row.
REQ-021 0x08 (BS): col>0 -> col-1 and FILL_CHAR written at the new position; col==0 -> no action.
REQ-022 0x0C (FF): CLR_ALL, then cursor = (0,0).
REQ-023 Any other byte SHALL be ignored: no write, no cursor change.
REQ-024 CLR_LINE SHALL write FILL_CHAR to the new row's COLS addresses in ascending order, one per cycle, then return to IDLE.
REQ-025 CLR_ALL SHALL write FILL_CHAR to addresses 0..COLS*ROWS-1 ascending, one per cycle, then go to IDLE with cursor (0,0).
REQ-026 write_data, write_address, write_enable SHALL be registered outputs; write_enable low in IDLE.
REQ-027 A pulse of data_ready coinciding with the last clear write SHALL be buffered, not decoded in the same cycle.

Reset
REQ-028 While reset is high: state=CLR_ALL, clear counter=0, cursor=(0,0), buffer empty, write_enable=0, write_address=0, write_data=FILL_CHAR, overflow=0, busy=1.
REQ-029 After reset is released, the first clear write SHALL occur on the first rising edge.
REQ-030 Reset asserted mid-operation SHALL abort the operation immediately; the clear restarts from address 0.

Verification
REQ-031 Release reset, defaults -> exactly 3700 writes of 8'h20 to 0..3699 consecutively, then busy=0.
REQ-032 After the clear, send 'A' (0x41) -> one write of 0x41 to address 0 one cycle after data_ready; next 'B' -> write to address 1.
REQ-033 Cursor at (0,99), send 'Z' -> write 0x5A at address 99, then 100 writes of 0x20 to 100..199, cursor (1,0).
REQ-034 Cursor (36,5), send 0x0A -> 100 clear writes to 0..99, cursor (0,5); then 0x0D -> cursor (0,0), no write.
REQ-035 Cursor (2,10), send 0x08 -> write 0x20 at address 209; cursor (2,0), send 0x08 -> no write.
REQ-036 During CLR_LINE, send 3 bytes -> first buffered and processed after the clear, second and third dropped, one overflow pulse each.
